// File: rtl/lane_scroll_nv.sv
// lane_scroll_nv: one vehicle lane of the playfield.
// Holds a W-cell lane image, reloads a per-level pattern on a level-change
// request and rotates it circularly once every PERIODS[level]+1 cycles.
// The rate comes from a clock-enable prescaler; there is one clock only.
// Optional feature macro: LANE_SCROLL_NV_COLLISION_EN adds the FROG_IN /
// HIT_OUT pair that flags overlap between the frog cell and the lane image.
//
// Handshake note: there is no valid/ready pair here. LOADED_OUT and TICK_OUT
// are one-cycle strobes that qualify the registered image; consumers may
// sample DATAPARALLEL_OUT on any cycle and treat a strobe as "image changed".
module lane_scroll_nv #(
    parameter int DATAWIDTH_BUS   = 8,
    parameter int DATAWIDTH_NIVEL = 2,
    parameter int PERIOD_WIDTH    = 24,
    parameter logic [(2**DATAWIDTH_NIVEL)*DATAWIDTH_BUS-1:0] PATTERNS = '0,
    parameter logic [(2**DATAWIDTH_NIVEL)*PERIOD_WIDTH-1:0]  PERIODS  = '0
) (
    input  logic                       LANE_SCROLL_NV_CLOCK,
    input  logic                       LANE_SCROLL_NV_RESET,
    input  logic [DATAWIDTH_NIVEL-1:0] LANE_SCROLL_NV_NVL_IN,
    input  logic                       LANE_SCROLL_NV_CN_IN,
    input  logic                       LANE_SCROLL_NV_DIR_IN,
    input  logic                       LANE_SCROLL_NV_PAUSE_IN,
`ifdef LANE_SCROLL_NV_COLLISION_EN
    input  logic [DATAWIDTH_BUS-1:0]   LANE_SCROLL_NV_FROG_IN,
    output logic                       LANE_SCROLL_NV_HIT_OUT,
`endif
    output logic [DATAWIDTH_BUS-1:0]   LANE_SCROLL_NV_DATAPARALLEL_OUT,
    output logic [DATAWIDTH_NIVEL-1:0] LANE_SCROLL_NV_LEVEL_OUT,
    output logic                       LANE_SCROLL_NV_LOADED_OUT,
    output logic                       LANE_SCROLL_NV_TICK_OUT,
    output logic [1:0]                 LANE_SCROLL_NV_STATE_DBG_OUT
);

    localparam int W = DATAWIDTH_BUS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                     state_q;
    logic [DATAWIDTH_NIVEL-1:0] lvl_q;      // level latched on the request
    logic [PERIOD_WIDTH-1:0]    cnt_q;      // prescaler, never exceeds period

    logic [W-1:0]               pattern_sel;
    logic [PERIOD_WIDTH-1:0]    period_sel;
    logic                       shift_due;
    logic [W-1:0]               img_nx;

    assign LANE_SCROLL_NV_STATE_DBG_OUT = state_q;

    // Select the pattern/period of the latched level and form the image that
    // will be written on the coming edge (shared by the image and hit logic).
    always_comb begin
        pattern_sel = PATTERNS[lvl_q*W +: W];
        period_sel  = PERIODS[lvl_q*PERIOD_WIDTH +: PERIOD_WIDTH];
        shift_due   = (cnt_q == period_sel);
        img_nx      = LANE_SCROLL_NV_DATAPARALLEL_OUT;
        case (state_q)
            ST_LOAD: img_nx = pattern_sel;
            ST_RUN: begin
                // A level request outranks pause and a pending shift.
                if (!LANE_SCROLL_NV_CN_IN && !LANE_SCROLL_NV_PAUSE_IN && shift_due) begin
                    if (LANE_SCROLL_NV_DIR_IN)
                        img_nx = {LANE_SCROLL_NV_DATAPARALLEL_OUT[0],
                                  LANE_SCROLL_NV_DATAPARALLEL_OUT[W-1:1]};
                    else
                        img_nx = {LANE_SCROLL_NV_DATAPARALLEL_OUT[W-2:0],
                                  LANE_SCROLL_NV_DATAPARALLEL_OUT[W-1]};
                end
            end
            default: img_nx = LANE_SCROLL_NV_DATAPARALLEL_OUT;
        endcase
    end

    // Control FSM with all outputs registered; strobes default low each cycle.
    always_ff @(posedge LANE_SCROLL_NV_CLOCK) begin
        if (LANE_SCROLL_NV_RESET) begin
            state_q                         <= ST_IDLE;
            lvl_q                           <= '0;
            cnt_q                           <= '0;
            LANE_SCROLL_NV_DATAPARALLEL_OUT <= '0;
            LANE_SCROLL_NV_LEVEL_OUT        <= '0;
            LANE_SCROLL_NV_LOADED_OUT       <= 1'b0;
            LANE_SCROLL_NV_TICK_OUT         <= 1'b0;
        end else begin
            LANE_SCROLL_NV_LOADED_OUT       <= 1'b0;
            LANE_SCROLL_NV_TICK_OUT         <= 1'b0;
            LANE_SCROLL_NV_DATAPARALLEL_OUT <= img_nx;
            case (state_q)
                ST_IDLE: begin
                    if (LANE_SCROLL_NV_CN_IN) begin
                        lvl_q   <= LANE_SCROLL_NV_NVL_IN;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Load uses the level latched earlier; a request arriving
                    // now re-latches and forces another load cycle.
                    cnt_q                     <= '0;
                    LANE_SCROLL_NV_LOADED_OUT <= 1'b1;
                    LANE_SCROLL_NV_LEVEL_OUT  <= lvl_q;
                    if (LANE_SCROLL_NV_CN_IN) begin
                        lvl_q   <= LANE_SCROLL_NV_NVL_IN;
                        state_q <= ST_LOAD;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (LANE_SCROLL_NV_CN_IN) begin
                        lvl_q   <= LANE_SCROLL_NV_NVL_IN;
                        state_q <= ST_LOAD;
                    end else if (LANE_SCROLL_NV_PAUSE_IN) begin
                        cnt_q <= cnt_q;
                    end else if (shift_due) begin
                        cnt_q                   <= '0;
                        LANE_SCROLL_NV_TICK_OUT <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + PERIOD_WIDTH'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef LANE_SCROLL_NV_COLLISION_EN
    // Collision flag against the image being written on this edge.
    always_ff @(posedge LANE_SCROLL_NV_CLOCK) begin
        if (LANE_SCROLL_NV_RESET || state_q == ST_IDLE)
            LANE_SCROLL_NV_HIT_OUT <= 1'b0;
        else
            LANE_SCROLL_NV_HIT_OUT <= |(img_nx & LANE_SCROLL_NV_FROG_IN);
    end
`endif

endmodule

// File: doc/lane_scroll_nv.md
# lane_scroll_nv

Parametrised lane-traffic generator for the vehicle rows of the frogger playfield. It holds one W-bit lane image, loads a per-level pattern on a level-change request and rotates it at a per-level rate. The rate comes from a clock-enable prescaler, not a muxed or derived clock. Each road lane in the vehicles subsystem instantiates one copy, and the display and collision logic consume it.

## Interface
- DATAWIDTH_BUS, 8: lane width W in cells (≥2)
- DATAWIDTH_NIVEL, 2: level-select width; NLEVELS = 2^DATAWIDTH_NIVEL
- PERIOD_WIDTH, 24: prescaler counter width
- PATTERNS, 0: packed NLEVELS×W; level k pattern at bits [k*W +: W]
- PERIODS, 0: packed NLEVELS×PERIOD_WIDTH; level k period at [k*PERIOD_WIDTH +: PERIOD_WIDTH]
- LANE_SCROLL_NV_CLOCK  in  1  the only clock; all logic on rising edge
- LANE_SCROLL_NV_RESET  in  1  synchronous, active-high reset
- LANE_SCROLL_NV_NVL_IN  in  DATAWIDTH_NIVEL  requested level, sampled when CN_IN=1
- LANE_SCROLL_NV_CN_IN  in  1  level-change request (single-cycle or held)
- LANE_SCROLL_NV_DIR_IN  in  1  0 = rotate toward MSB (left), 1 = toward LSB (right)
- LANE_SCROLL_NV_PAUSE_IN  in  1  freezes prescaler and lane image
- LANE_SCROLL_NV_DATAPARALLEL_OUT  out  W  current lane image, registered
- LANE_SCROLL_NV_LEVEL_OUT  out  DATAWIDTH_NIVEL  level currently applied
- LANE_SCROLL_NV_LOADED_OUT  out  1  one-cycle pulse: pattern just loaded
- LANE_SCROLL_NV_TICK_OUT  out  1  one-cycle pulse: lane just shifted

## Operation
- States: IDLE, LOAD, RUN. Reset forces IDLE.
- IDLE: outputs hold reset values. CN_IN=1 latches NVL_IN into the level register and moves to LOAD.
- LOAD takes one cycle. On that edge: DATAPARALLEL_OUT ← PATTERNS[level], counter ← 0, LOADED_OUT ← 1, LEVEL_OUT ← level. Next state is RUN. If CN_IN=1 during LOAD, the new level is latched and the next state is LOAD again.
- RUN, priority from highest:
  1. CN_IN: latch level, go to LOAD. A pending tick is discarded.
  2. PAUSE_IN: counter and image hold, TICK_OUT=0.
  3. counter == PERIODS[level]: counter ← 0, image rotates by one cell in DIR_IN direction, TICK_OUT ← 1.
  4. Otherwise: counter+1.
- Rotation is circular with no loss of bits. Left: {d[W-2:0], d[W-1]}. Right: {d[0], d[W-1:1]}.
- DIR_IN is sampled on the shift edge only, so a direction change takes effect at the next tick.
- Period 0 means a shift on every RUN cycle. The shift interval is PERIODS[level]+1 cycles.
- The counter never exceeds the period value, so no wrap occurs within PERIOD_WIDTH.
- A held CN_IN keeps the block in LOAD, reloading every cycle. The image stays at the pattern and LOADED_OUT stays high.

## Timing
- Reset values: DATAPARALLEL_OUT=0, LEVEL_OUT=0, LOADED_OUT=0, TICK_OUT=0, counter=0, state=IDLE.
- Reset asserted mid-operation takes effect on the next edge and overrides every other input.
- Latency: CN_IN high at edge n → LOAD at n+1 → pattern visible and LOADED_OUT=1 after edge n+2.
- First shift happens PERIODS[level]+1 edges after the load edge.
- TICK_OUT and the new image appear together on the same edge.
- All outputs are registered, with no combinational input-to-output path.

## Configuration
- LANE_SCROLL_NV_COLLISION_EN defined:
  - Adds LANE_SCROLL_NV_FROG_IN (in, W, one-hot frog cell).
  - Adds LANE_SCROLL_NV_HIT_OUT (out, 1).
  - HIT_OUT is registered as |(image_next & FROG_IN), evaluated against the image value being written on that edge.
  - HIT_OUT is 0 in IDLE and on reset.
- Undefined: neither port exists and no collision logic is generated.

## Test plan
- Reset, then hold CN_IN=0 for 20 cycles → DATAPARALLEL_OUT=0x00, all pulses 0, LEVEL_OUT=0.
- PATTERNS L1=0x81, PERIODS L1=3. CN_IN pulse with NVL_IN=1 at edge n:
  - Edge n+2: 0x81, LOADED_OUT=1.
  - Edge n+6 (DIR=0): 0x03, TICK_OUT=1.
  - Edge n+10: 0x06.
- Same as above with DIR=1: image goes 0x81 → 0xC0 → 0x60. Flip DIR mid-interval: the first tick after the flip uses the new direction.
- PERIODS L0=0, pattern 0x01 → image 0x02, 0x04, … 0x80, 0x01 on consecutive cycles. TICK_OUT is high every cycle.
- PAUSE_IN high for 5 cycles in RUN → image and counter frozen. After release, the next tick is delayed by exactly 5 cycles.
- CN_IN to level 2 (pattern 0x0F) on the same cycle a tick is due → no shift, LOAD, then 0x0F with LOADED_OUT=1. With COLLISION_EN, FROG_IN=0x08 → HIT_OUT=1 on the load edge.
